epl_ffbit_wr_sched: RTL and testbench

EPL_FFBIT_WR_SCHED -- requirements
Module: epl_ffbit_wr_sched

---
 rtl/epl_ffbit_pkg.sv | 20 ++
 rtl/epl_rr_arb.sv | 28 ++
 rtl/epl_ffbit_wr_sched.sv | 119 +++++++++++
 tb/tb_epl_ffbit_wr_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/epl_ffbit_pkg.sv
// Shared encodings for the flag-bit write scheduler: per-requester opcodes,
// FSM states and the optional write-counter width.
package epl_ffbit_pkg;

    typedef enum logic [1:0] {
        OP_CLR = 2'b00,
        OP_SET = 2'b01,
        OP_TGL = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GNT  = 1'b1
    } state_e;

    localparam int             CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/epl_rr_arb.sv
// Combinational round-robin picker: the search starts at index ptr and wraps,
// returning a one-hot vector for the first active request found.
module epl_rr_arb #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/epl_ffbit_wr_sched.sv
// Round-robin write scheduler for a bank of single flag bits (CLR/SET/TGL).
// Defining EPL_FFBIT_SCHED_CNT_EN adds pWrCnt_o, a saturating valid-write counter.
module epl_ffbit_wr_sched
    import epl_ffbit_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BITS = 16,
    parameter int ADDR_W   = 6
) (
    input  logic                      pClk_i,
    input  logic                      pRst_i,
    input  logic [NUM_REQ-1:0]        pReq_i,
    input  logic [NUM_REQ*ADDR_W-1:0] pAddr_i,
    input  logic [NUM_REQ*2-1:0]      pOp_i,
    input  logic [NUM_BITS-1:0]       pDtoc_i,
    output logic [NUM_BITS-1:0]       pWec_o,
    output logic [NUM_BITS-1:0]       pDic_o,
    output logic [NUM_REQ-1:0]        pGnt_o,
    output logic                      pBusy_o,
    output logic                      pErr_o
`ifdef EPL_FFBIT_SCHED_CNT_EN
    ,
    output logic [CNT_W-1:0]          pWrCnt_o
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state;
    logic [PTR_W-1:0]    ptr;
    logic [NUM_REQ-1:0]  win;
    logic [PTR_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   win_addr;
    op_e                 win_op;
    logic                valid;
    logic [NUM_BITS-1:0] wec_n;
    logic [NUM_BITS-1:0] dic_n;

    epl_rr_arb #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (pReq_i),
        .ptr (ptr),
        .gnt (win)
    );

    always_comb begin
        win_idx = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (win[r]) win_idx = PTR_W'(r);
        end
    end

    assign win_addr = pAddr_i[int'(win_idx)*ADDR_W +: ADDR_W];
    assign win_op   = op_e'(pOp_i[int'(win_idx)*2 +: 2]);
    assign valid    = (win_op != OP_RSV) && (int'(win_addr) < NUM_BITS);

    // Loop over bit cells so an out-of-range address never indexes pDtoc_i.
    always_comb begin
        wec_n = '0;
        dic_n = '0;
        for (int b = 0; b < NUM_BITS; b++) begin
            if (valid && int'(win_addr) == b) begin
                wec_n[b] = 1'b1;
                case (win_op)
                    OP_SET:  dic_n[b] = 1'b1;
                    OP_TGL:  dic_n[b] = ~pDtoc_i[b];
                    default: dic_n[b] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge pClk_i) begin
        if (pRst_i) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            pWec_o  <= '0;
            pDic_o  <= '0;
            pGnt_o  <= '0;
            pBusy_o <= 1'b0;
            pErr_o  <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by later assignments in the same edge.
            pWec_o  <= '0;
            pDic_o  <= '0;
            pGnt_o  <= '0;
            pBusy_o <= 1'b0;
            pErr_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|pReq_i) begin
                        state   <= ST_GNT;
                        pGnt_o  <= win;
                        pBusy_o <= 1'b1;
                        pWec_o  <= wec_n;
                        pDic_o  <= dic_n;
                        pErr_o  <= ~valid;
                        ptr     <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef EPL_FFBIT_SCHED_CNT_EN
    // Count on the edge that ends GNT, which is the edge the bank is written.
    always_ff @(posedge pClk_i) begin
        if (pRst_i) begin
            pWrCnt_o <= '0;
        end else if (state == ST_GNT && (|pWec_o) && pWrCnt_o != CNT_MAX) begin
            pWrCnt_o <= pWrCnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_epl_ffbit_wr_sched.sv
// Self-checking bench for epl_ffbit_wr_sched: directed scenarios plus random rounds
// checked against a behavioural model of arbitration and the bit bank.
module tb_epl_ffbit_wr_sched;

    localparam int NR = 4;
    localparam int NB = 16;
    localparam int AW = 6;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] addr_bus;
    logic [NR*2-1:0]  op_bus;
    logic [NB-1:0]    bank = '0;
    logic [NB-1:0]    wec;
    logic [NB-1:0]    dic;
    logic [NR-1:0]    gnt;
    logic             busy;
    logic             err;
`ifdef EPL_FFBIT_SCHED_CNT_EN
    logic [15:0]      cnt;
`endif

    int            total = 0;
    int            bad   = 0;
    int            last;
    int            ref_cnt;
    int            obs_gnt;
    logic [NB-1:0] ref_bank = '0;

    epl_ffbit_wr_sched #(
        .NUM_REQ  (NR),
        .NUM_BITS (NB),
        .ADDR_W   (AW)
    ) dut (
        .pClk_i   (clk),
        .pRst_i   (rst),
        .pReq_i   (req),
        .pAddr_i  (addr_bus),
        .pOp_i    (op_bus),
        .pDtoc_i  (bank),
        .pWec_o   (wec),
        .pDic_o   (dic),
        .pGnt_o   (gnt),
        .pBusy_o  (busy),
        .pErr_o   (err)
`ifdef EPL_FFBIT_SCHED_CNT_EN
        ,
        .pWrCnt_o (cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural flag-bit bank driven by the scheduler's write strobes.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wec[b]) bank[b] <= dic[b];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input int a);
        req[r]             = 1'b1;
        op_bus[r*2 +: 2]   = op;
        addr_bus[r*AW +: AW] = AW'(a);
    endtask

    // Reference rule: first active requester after the last one granted.
    function automatic int pick(input logic [NR-1:0] rq);
        for (int k = 1; k <= NR; k++) begin
            if (rq[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt0"},  gnt,  0);
        check({tag, "_busy0"}, busy, 0);
        check({tag, "_wec0"},  wec,  0);
        check({tag, "_dic0"},  dic,  0);
        check({tag, "_err0"},  err,  0);
    endtask

    task automatic do_reset();
        req  = '0;
        rst  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        check_idle_outputs("reset");
        last    = NR - 1;
        ref_cnt = 0;
    endtask

    // One arbitration: sample edge, GNT cycle check, then the edge that writes the bank.
    task automatic run_round(input string tag);
        int            w;
        int            a;
        logic [1:0]    o;
        logic          ok;
        logic [NB-1:0] ew;
        logic [NB-1:0] ed;
        w  = pick(req);
        a  = int'(addr_bus[w*AW +: AW]);
        o  = op_bus[w*2 +: 2];
        ok = (o != 2'b11) && (a < NB);
        ew = '0;
        ed = '0;
        if (ok) begin
            ew[a] = 1'b1;
            if (o == 2'b01)      ed[a] = 1'b1;
            else if (o == 2'b10) ed[a] = ~ref_bank[a];
        end
        @(posedge clk);
        @(negedge clk);
        obs_gnt = int'(gnt);
        check({tag, "_gnt"},  gnt,  64'(1) << w);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_wec"},  wec,  ew);
        check({tag, "_dic"},  dic,  ed);
        check({tag, "_err"},  err,  !ok);
        if (ok) begin
            ref_bank[a] = ed[a];
            if (ref_cnt < 65535) ref_cnt++;
        end
        last   = w;
        req[w] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_gnt_low"},  gnt,  0);
        check({tag, "_wec_low"},  wec,  0);
        check({tag, "_bank"},     bank, ref_bank);
`ifdef EPL_FFBIT_SCHED_CNT_EN
        check({tag, "_cnt"}, cnt, 64'(ref_cnt));
`endif
    endtask

    initial begin
        int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        req      = '0;
        addr_bus = '0;
        op_bus   = '0;
        rst      = 1'b1;
        do_reset();

        // Single SET on bit 5.
        set_req(0, 2'b01, 5);
        run_round("set5");
        check("set5_gnt_req0", obs_gnt, 1);
        check("set5_bank_bit", bank[5], 1);

        // All four requesters continuously requesting.
        do_reset();
        for (int r = 0; r < NR; r++) set_req(r, 2'b01, 8 + r);
        for (int g = 0; g < 8; g++) begin
            run_round($sformatf("rr%0d", g));
            check($sformatf("rr%0d_order", g), obs_gnt, 1 << order[g]);
            req[order[g]] = 1'b1;
        end
        req = '0;

        // Back-to-back toggles of bit 3 from a known 0.
        set_req(1, 2'b00, 3);
        run_round("clr3");
        set_req(1, 2'b10, 3);
        run_round("tgl3a");
        check("tgl3a_bit", bank[3], 1);
        set_req(1, 2'b10, 3);
        run_round("tgl3b");
        check("tgl3b_bit", bank[3], 0);

        // Out-of-range address and reserved op still grant but never write.
        set_req(2, 2'b01, 20);
        run_round("oor");
        check("oor_gnt2", obs_gnt, 4);
        set_req(2, 2'b11, 4);
        run_round("rsv");
        check("rsv_gnt2", obs_gnt, 4);
        check("rsv_bit4", bank[4], 0);

        // Reset while a grant is active: write still lands, no retry, priority restarts at 0.
        do_reset();
        set_req(2, 2'b01, 7);
        set_req(3, 2'b01, 9);
        @(posedge clk);
        @(negedge clk);
        check("rstg_gnt", gnt, 4);
        rst         = 1'b1;
        req[2]      = 1'b0;
        ref_bank[7] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rstg");
        check("rstg_bank", bank, ref_bank);
        last    = NR - 1;
        ref_cnt = 0;
        set_req(0, 2'b00, 7);
        set_req(1, 2'b01, 1);
        run_round("rstg_next");
        check("rstg_first0", obs_gnt, 1);
        run_round("rstg_next2");
        run_round("rstg_next3");
        req = '0;

        // Random traffic; pending requesters keep their address and op.
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req[r] && $urandom_range(0, 1) == 1)
                    set_req(r, 2'($urandom_range(0, 3)), int'($urandom_range(0, 23)));
            end
            if (req == '0) set_req(int'($urandom_range(0, NR - 1)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 23)));
            run_round($sformatf("rnd%0d", n));
        end
        req = '0;

`ifdef EPL_FFBIT_SCHED_CNT_EN
        // Three valid writes and one error leave the counter at 3.
        do_reset();
        set_req(0, 2'b01, 2);
        run_round("cnt_a");
        set_req(1, 2'b00, 2);
        run_round("cnt_b");
        set_req(2, 2'b11, 2);
        run_round("cnt_err");
        set_req(3, 2'b10, 6);
        run_round("cnt_c");
        check("cnt_final", cnt, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
